// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: minuend - subtrahend - borrow_in, one bit per clock, LSB first,
// through a single full-subtractor cell, with valid/ready handshakes on operands and result.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] min_sr, sub_sr, res_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a, b, d, br_nx, last;

  // Full-subtractor cell: returns {difference bit, borrow out}.
  function automatic logic [1:0] fsub(input logic fa, input logic fb, input logic fbi);
    logic fd, fbo;
    fd  = fa ^ fb ^ fbi;
    fbo = (~fa & fb) | (fbi & ~(fa ^ fb));
    return {fd, fbo};
  endfunction

  assign a    = min_sr[0];
  assign b    = sub_sr[0];
  assign {d, br_nx} = fsub(a, b, br);
  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
    end
  end

  // Operands shift right so the cell always sees bit `cnt` at position 0; the result
  // fills from the MSB side. On the final bit the shifted-out MSBs are still at [0].
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      min_sr     <= '0;
      sub_sr     <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      difference <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            min_sr <= minuend;
            sub_sr <= subtrahend;
            br     <= borrow_in;
            cnt    <= '0;
          end
        end
        RUN: begin
          min_sr <= {1'b0, min_sr[WIDTH-1:1]};
          sub_sr <= {1'b0, sub_sr[WIDTH-1:1]};
          res_sr <= {d, res_sr[WIDTH-1:1]};
          br     <= br_nx;
          cnt    <= cnt + 1'b1;
          if (last) begin
            difference <= {d, res_sr[WIDTH-1:1]};
            borrow_out <= br_nx;
            overflow   <= (a != b) && (d != a);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes hand-computed results, a monitor
// pops and compares on every accepted output.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] difference;
  logic             borrow_out;
  logic             overflow;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .minuend(minuend), .subtrahend(subtrahend), .borrow_in(borrow_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .difference(difference), .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand set and hold it until accepted; optionally register the expected result.
  task automatic accept_op(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] s, input logic bi,
                           input logic push, input logic [WIDTH-1:0] ed, input logic eb,
                           input logic eo);
    exp_t e;
    int   w;
    w = 0;
    while (!in_ready && w < 40) begin
      tick();
      w++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid   = 1'b1;
    minuend    = m;
    subtrahend = s;
    borrow_in  = bi;
    if (push) begin
      e.diff = ed; e.bout = eb; e.ovf = eo;
      exp_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check(name, cyc, WIDTH);
  endtask

  // Monitor: compares every consumed result against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("difference", {24'd0, difference}, {24'd0, e.diff});
          check("borrow_out", {31'd0, borrow_out}, {31'd0, e.bout});
          check("overflow",   {31'd0, overflow},   {31'd0, e.ovf});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] held_d;
    logic             held_b, held_o;

    resetn = 1'b0; in_valid = 1'b0; minuend = '0; subtrahend = '0;
    borrow_in = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_in_ready",   {31'd0, in_ready},   32'd1);
    check("rst_out_valid",  {31'd0, out_valid},  32'd0);
    check("rst_difference", {24'd0, difference}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    accept_op(8'd100, 8'd37, 1'b0, 1'b1, 8'd63, 1'b0, 1'b0);
    wait_result("latency_100_37");
    accept_op(8'd5, 8'd10, 1'b0, 1'b1, 8'd251, 1'b1, 1'b0);
    wait_result("latency_5_10");
    accept_op(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    wait_result("latency_0_0_b");
    accept_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    wait_result("latency_80_01");
    accept_op(8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1);
    wait_result("latency_7f_ff");
    tick();

    // Backpressure: result must hold while operands and in_valid churn.
    out_ready = 1'b0;
    accept_op(8'd50, 8'd20, 1'b0, 1'b1, 8'd30, 1'b0, 1'b0);
    wait_result("latency_bp");
    held_d = difference; held_b = borrow_out; held_o = overflow;
    check("bp_value", {24'd0, held_d}, 32'd30);
    for (int i = 0; i < 5; i++) begin
      in_valid   = ~in_valid;
      minuend    = 8'(i * 37 + 3);
      subtrahend = 8'(i * 11 + 90);
      borrow_in  = i[0];
      tick();
      check("bp_difference_held", {24'd0, difference}, {24'd0, held_d});
      check("bp_flags_held", {30'd0, borrow_out, overflow}, {30'd0, held_b, held_o});
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid_high", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_consume_in_ready",  {31'd0, in_ready},   32'd1);
    check("post_consume_out_valid", {31'd0, out_valid},  32'd0);
    check("post_consume_held",      {24'd0, difference}, 32'd30);
    accept_op(8'd200, 8'd55, 1'b0, 1'b1, 8'd145, 1'b0, 1'b0);
    wait_result("latency_200_55");
    tick();

    // Reset in the middle of a run discards the partial result.
    accept_op(8'h33, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    resetn = 1'b0;
    #1;
    check("midrst_in_ready",   {31'd0, in_ready},   32'd1);
    check("midrst_out_valid",  {31'd0, out_valid},  32'd0);
    check("midrst_difference", {24'd0, difference}, 32'd0);
    check("midrst_flags", {30'd0, borrow_out, overflow}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    accept_op(8'd7, 8'd9, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
    wait_result("latency_7_9");
    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
